// File: rtl/dmem_ldst_seq.sv
// dmem_ldst_seq: round-robin load/store arbiter and strided address sequencer for one data-memory port.
// Optional macro DMEM_SEQ_BOUND_CHK_EN: a beat whose address increment carries out sets O_Err and ends the transfer.

package dmem_pkg;
  localparam int WIDTH_SIZE_DMEM = 10;

  typedef struct packed {
    logic                       req;
    logic [WIDTH_SIZE_DMEM-1:0] len;
    logic [WIDTH_SIZE_DMEM-1:0] stride;
    logic [WIDTH_SIZE_DMEM-1:0] base;
  } dmem_t;
endpackage

module dmem_ldst_seq
  import dmem_pkg::*;
#(
  parameter int WIDTH_ADDR = WIDTH_SIZE_DMEM
) (
  input  logic                  clock,
  input  logic                  reset,
  input  dmem_t                 I_Ld,
  input  dmem_t                 I_St,
  output logic                  O_Ld_Ack,
  output logic                  O_St_Ack,
  output logic                  O_Ld_Done,
  output logic                  O_St_Done,
  output logic                  O_Mem_Req,
  output logic                  O_Mem_We,
  output logic [WIDTH_ADDR-1:0] O_Mem_Addr,
  input  logic                  I_Mem_Ready,
  input  logic                  I_St_Valid,
  output logic                  O_St_Pop,
  output logic                  O_Busy,
  output logic                  O_Err
);

  typedef enum logic [1:0] {IDLE, RUN_LD, RUN_ST} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WIDTH_ADDR-1:0] r_addr;
  logic [WIDTH_ADDR-1:0] r_stride;
  logic [WIDTH_ADDR-1:0] r_len;
  logic [WIDTH_ADDR-1:0] r_cnt;
  logic [WIDTH_ADDR-1:0] w_addr_next;
  logic                  r_last_ld;
  logic                  r_ld_ack;
  logic                  r_st_ack;
  logic                  r_ld_done;
  logic                  r_st_done;
  logic                  w_mem_req;
  logic                  w_mem_we;
  logic                  w_busy;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_carry;
  logic                  w_finish;
  logic                  w_ack_pend;
  logic                  w_arb_en;
  logic                  w_grant_ld;
  logic                  w_grant_st;

`ifdef DMEM_SEQ_BOUND_CHK_EN
  logic r_err;
  assign {w_carry, w_addr_next} = {1'b0, r_addr} + {1'b0, r_stride};
  assign O_Err = r_err;
`else
  assign w_addr_next = r_addr + r_stride;
  assign w_carry     = 1'b0;
  assign O_Err       = 1'b0;
`endif

  assign w_beat   = w_mem_req & I_Mem_Ready;
  assign w_last   = w_beat & (r_cnt == r_len - WIDTH_ADDR'(1));
  assign w_finish = w_last | (w_beat & w_carry);

  // The Ack cycle is a registered grant still sitting in IDLE; arbitrating there would regrant the
  // same still-high request. Arbitrating on the finishing beat lets the next Ack share the Done cycle.
  assign w_ack_pend = r_ld_ack | r_st_ack;
  assign w_arb_en   = ((r_state == IDLE) & ~w_ack_pend) | w_finish;
  assign w_grant_ld = w_arb_en & I_Ld.req & (~I_St.req | ~r_last_ld);
  assign w_grant_st = w_arb_en & I_St.req & (~I_Ld.req | r_last_ld);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_ld_ack && r_len != '0) begin
          w_state_next = RUN_LD;
        end else if (r_st_ack && r_len != '0) begin
          w_state_next = RUN_ST;
        end
      end
      RUN_LD, RUN_ST: begin
        if (w_finish) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    w_busy    = 1'b1;
    case (r_state)
      RUN_LD: w_mem_req = 1'b1;
      RUN_ST: begin
        w_mem_req = I_St_Valid;
        w_mem_we  = 1'b1;
      end
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_addr    <= '0;
      r_stride  <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_last_ld <= 1'b0;
      r_ld_ack  <= 1'b0;
      r_st_ack  <= 1'b0;
      r_ld_done <= 1'b0;
      r_st_done <= 1'b0;
`ifdef DMEM_SEQ_BOUND_CHK_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_ld_ack  <= w_grant_ld;
      r_st_ack  <= w_grant_st;
      r_ld_done <= ((r_state == RUN_LD) & w_finish) | (r_ld_ack & (r_len == '0));
      r_st_done <= ((r_state == RUN_ST) & w_finish) | (r_st_ack & (r_len == '0));
      if (w_grant_ld | w_grant_st) begin
        r_last_ld <= w_grant_ld;
        r_addr    <= WIDTH_ADDR'(w_grant_ld ? I_Ld.base : I_St.base);
        r_stride  <= WIDTH_ADDR'(w_grant_ld ? I_Ld.stride : I_St.stride);
        r_len     <= WIDTH_ADDR'(w_grant_ld ? I_Ld.len : I_St.len);
        r_cnt     <= '0;
      end else if (w_beat) begin
        r_addr <= w_addr_next;
        r_cnt  <= r_cnt + WIDTH_ADDR'(1);
      end
`ifdef DMEM_SEQ_BOUND_CHK_EN
      if (w_beat & w_carry) begin
        r_err <= 1'b1;
      end
`endif
    end
  end

  assign O_Ld_Ack   = r_ld_ack;
  assign O_St_Ack   = r_st_ack;
  assign O_Ld_Done  = r_ld_done;
  assign O_St_Done  = r_st_done;
  assign O_Mem_Req  = w_mem_req;
  assign O_Mem_We   = w_mem_we;
  assign O_Mem_Addr = r_addr;
  assign O_St_Pop   = w_mem_req & w_mem_we & I_Mem_Ready;
  assign O_Busy     = w_busy;

endmodule

// File: tb/tb_dmem_ldst_seq.sv
// Self-checking bench for dmem_ldst_seq: directed timing cases plus randomized transfers
// checked against a descriptor-level model (beat k lands at base + k*stride).

module tb_dmem_ldst_seq;
  import dmem_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  dmem_t      ld_d;
  dmem_t      st_d;
  logic       mem_ready;
  logic       st_valid;
  logic       ld_ack, st_ack, ld_done, st_done;
  logic       mem_req, mem_we, st_pop, busy, err;
  logic [9:0] mem_addr;

  int n_tests = 0;
  int n_fail  = 0;
  bit m_last_ld = 1'b0;
  bit m_err     = 1'b0;

  always #5 clock = ~clock;

  dmem_ldst_seq dut (
    .clock      (clock),
    .reset      (reset),
    .I_Ld       (ld_d),
    .I_St       (st_d),
    .O_Ld_Ack   (ld_ack),
    .O_St_Ack   (st_ack),
    .O_Ld_Done  (ld_done),
    .O_St_Done  (st_done),
    .O_Mem_Req  (mem_req),
    .O_Mem_We   (mem_we),
    .O_Mem_Addr (mem_addr),
    .I_Mem_Ready(mem_ready),
    .I_St_Valid (st_valid),
    .O_St_Pop   (st_pop),
    .O_Busy     (busy),
    .O_Err      (err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic dmem_t mk(input bit req, input int len, input int stride, input int base);
    dmem_t d;
    d.req    = req;
    d.len    = 10'(len);
    d.stride = 10'(stride);
    d.base   = 10'(base);
    return d;
  endfunction

  function automatic logic [9:0] exp_addr(input dmem_t d, input int k);
    int v;
    v = int'(d.base) + k * int'(d.stride);
    return 10'(v);
  endfunction

  function automatic logic [18:0] all_outs();
    return {ld_ack, st_ack, ld_done, st_done, mem_req, mem_we, st_pop, busy, err, mem_addr};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One transfer from an arbitration-ready cycle through its Done cycle; returns in the Done cycle.
  task automatic do_xfer(input bit lr, input bit sr, input dmem_t ld_in, input dmem_t st_in,
                         input int stall_pct);
    bit    win_ld;
    bit    exp_req;
    dmem_t d;
    int    k;
    int    n_exp;
    int    budget;
    win_ld    = lr && (!sr || !m_last_ld);
    d         = win_ld ? ld_in : st_in;
    ld_d      = ld_in;
    st_d      = st_in;
    ld_d.req  = lr;
    st_d.req  = sr;
    mem_ready = 1'b0;
    st_valid  = 1'b0;
    n_exp     = int'(d.len);
`ifdef DMEM_SEQ_BOUND_CHK_EN
    for (int i = 0; i < int'(d.len); i++) begin
      n_exp = i + 1;
      if (int'(d.base) + (i + 1) * int'(d.stride) >= 1024) begin
        m_err = 1'b1;
        break;
      end
    end
`endif
    $display("[TB] xfer %s base=0x%03h stride=0x%03h len=%0d stall=%0d%%",
             win_ld ? "LD" : "ST", d.base, d.stride, d.len, stall_pct);
    #1;
    check_val("ack_pre", {ld_ack, st_ack}, 2'b00);
    tick();
    // Descriptor changes after capture must be ignored.
    ld_d.base   = 10'($urandom);
    ld_d.len    = 10'($urandom);
    st_d.stride = 10'($urandom);
    st_d.base   = 10'($urandom);
    #1;
    check_val("ack", {ld_ack, st_ack, ld_done, st_done, busy, mem_req},
              {win_ld, !win_ld, 4'b0000});
    m_last_ld = win_ld;
    tick();
    ld_d.req = 1'b0;
    st_d.req = 1'b0;
    k        = 0;
    budget   = 20 + 8 * int'(d.len);
    while (k < n_exp && budget > 0) begin
      mem_ready = ($urandom_range(99) >= stall_pct);
      st_valid  = win_ld ? 1'($urandom) : ($urandom_range(99) >= stall_pct);
      #1;
      exp_req = win_ld ? 1'b1 : st_valid;
      check_val("mem_req", mem_req, exp_req);
      check_val("mem_we", mem_we, !win_ld);
      if (exp_req) check_val("mem_addr", mem_addr, exp_addr(d, k));
      check_val("st_pop", st_pop, !win_ld & st_valid & mem_ready);
      check_val("run_busy_done", {busy, ld_done, st_done}, 3'b100);
      if (exp_req && mem_ready) k++;
      budget--;
      tick();
    end
    if (k < n_exp) check_val("beat_timeout", k, n_exp);
    mem_ready = 1'b0;
    st_valid  = 1'b0;
    #1;
    check_val("done", {ld_done, st_done, busy, mem_req}, {win_ld, !win_ld, 2'b00});
    check_val("err", err, m_err);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    r;
    int    len;
    dmem_t a;
    dmem_t b;
    reset     = 1'b0;
    ld_d      = mk(0, 0, 0, 0);
    st_d      = mk(0, 0, 0, 0);
    mem_ready = 1'b0;
    st_valid  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_outs", {13'b0, all_outs()}, 32'h0);
    reset = 1'b1;

    // Simultaneous requests from reset: load first, store acked in the load's Done cycle.
    $display("[TB] b2b LD base=0x100 stride=8 len=2 then ST base=0x200 stride=1 len=2");
    ld_d      = mk(1, 2, 8, 'h100);
    st_d      = mk(1, 2, 1, 'h200);
    mem_ready = 1'b1;
    st_valid  = 1'b1;
    #1;
    check_val("b2b_pre", {ld_ack, st_ack}, 2'b00);
    tick(); #1;
    check_val("b2b_ld_ack", {ld_ack, st_ack}, 2'b10);
    tick(); ld_d.req = 1'b0; #1;
    check_val("b2b_ld_beat0", {mem_req, mem_we, mem_addr}, {2'b10, 10'h100});
    tick(); #1;
    check_val("b2b_ld_beat1", {mem_req, mem_we, mem_addr}, {2'b10, 10'h108});
    tick(); #1;
    check_val("b2b_done_ack", {ld_done, st_ack, busy, mem_req}, 4'b1100);
    tick(); st_d.req = 1'b0; #1;
    check_val("b2b_st_beat0", {mem_req, mem_we, st_pop, mem_addr}, {3'b111, 10'h200});
    tick(); #1;
    check_val("b2b_st_beat1", {mem_req, mem_we, st_pop, mem_addr}, {3'b111, 10'h201});
    tick(); #1;
    check_val("b2b_st_done", {st_done, ld_done, busy, mem_req}, 4'b1000);
    m_last_ld = 1'b0;

    do_xfer(1'b1, 1'b0, mk(1, 3, 4, 'h010), mk(0, 0, 0, 0), 0);
    do_xfer(1'b1, 1'b0, mk(1, 0, 4, 'h020), mk(0, 0, 0, 0), 0);
    do_xfer(1'b1, 1'b0, mk(1, 3, 4, 'h3FC), mk(0, 0, 0, 0), 0);
    do_xfer(1'b0, 1'b1, mk(0, 0, 0, 0), mk(1, 4, 2, 'h080), 40);
    do_xfer(1'b1, 1'b1, mk(1, 2, 1, 'h300), mk(1, 2, 1, 'h310), 10);

    for (int it = 0; it < 30; it++) begin
      r   = $urandom_range(1, 3);
      len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      a   = mk(1, len, $urandom_range(0, 1023), $urandom_range(0, 1023));
      len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      b   = mk(1, len, $urandom_range(0, 1023), $urandom_range(0, 1023));
      do_xfer(r[0], r[1], a, b, $urandom_range(0, 50));
    end

    // Reset during the second beat of a len=8 load.
    $display("[TB] reset mid-transfer LD base=0x050 stride=3 len=8");
    ld_d      = mk(1, 8, 3, 'h050);
    st_d      = mk(0, 0, 0, 0);
    mem_ready = 1'b1;
    tick(); #1;
    check_val("rst_ld_ack", ld_ack, 1'b1);
    tick(); ld_d.req = 1'b0; #1;
    check_val("rst_beat1", mem_addr, 10'h050);
    tick(); reset = 1'b0; #1;
    check_val("rst_beat2", mem_addr, 10'h053);
    tick(); reset = 1'b1; mem_ready = 1'b0; #1;
    check_val("rst_mid_outs", {13'b0, all_outs()}, 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick(); mem_ready = 1'b1; #1;
      check_val("rst_no_done", {ld_done, st_done, busy}, 3'b000);
    end
    m_last_ld = 1'b0;
    m_err     = 1'b0;
    do_xfer(1'b1, 1'b1, mk(1, 2, 5, 'h123), mk(1, 3, 7, 'h222), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
